// File: rtl/euler_result_uart.sv
// euler_result_uart: sends a solver's answer over an 8N1 UART as ASCII decimal followed by CR LF, once per completion.
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   clk, rst_n    system clock, asynchronous active-low reset
//   result        solver answer, latched when done first rises in IDLE
//   done, error   solver completion level and failure flag
//   tx            UART serial output, idle high
//   busy          high from capture until the last stop bit ends
//   sent          sticky, set once a report has been fully transmitted
module euler_result_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result,
    input  logic        done,
    input  logic        error,
    output logic        tx,
    output logic        busy,
    output logic        sent
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, CONVERT, SEND, REPORTED} state_t;
    state_t state;
    logic done_q, err_q;
    logic [31:0] val;
    logic [39:0] bcd, bcd_adj;
    logic [71:0] dd_next;
    logic [4:0] iter;
    logic [CW-1:0] cnt;
    logic [3:0] bit_idx, char_idx, nd, n_chars, dsel, dig;
    logic [7:0] ch;
    logic [9:0] frame;
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        dd_next = {bcd_adj, val} << 1;
        // nd ends up as one past the most significant non-zero digit, at least 1 so that 0 prints "0"
        nd = 4'd1;
        for (int i = 1; i < 10; i++)
            if (bcd[4*i +: 4] != 4'd0) nd = 4'(i + 1);
        n_chars = err_q ? 4'd5 : nd + 4'd2;
        dsel = nd - 4'd1 - char_idx;
        dig = 4'(bcd >> {dsel, 2'b00});
        ch = err_q ? (char_idx == 4'd0 ? 8'h45 : char_idx < 4'd3 ? 8'h52 : char_idx == 4'd3 ? 8'h0D : 8'h0A)
                   : (char_idx < nd ? {4'h3, dig} : char_idx == nd ? 8'h0D : 8'h0A);
        frame = {1'b1, ch, 1'b0};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            val      <= '0;
            bcd      <= '0;
            iter     <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            sent     <= 1'b0;
        end else begin
            done_q <= done;
            case (state)
                IDLE: if (done && !done_q) begin
                    busy     <= 1'b1;
                    err_q    <= error;
                    val      <= result;
                    bcd      <= '0;
                    iter     <= '0;
                    cnt      <= '0;
                    bit_idx  <= '0;
                    char_idx <= '0;
                    state    <= error ? SEND : CONVERT;
                end
                CONVERT: begin
                    bcd   <= dd_next[71:32];
                    val   <= dd_next[31:0];
                    iter  <= iter + 5'd1;
                    state <= iter == 5'd31 ? SEND : CONVERT;
                end
                SEND: if (char_idx == n_chars) begin
                    state <= REPORTED;
                    busy  <= 1'b0;
                    sent  <= 1'b1;
                    tx    <= 1'b1;
                end else begin
                    // tx is refreshed every cycle from the frame bit currently being held
                    tx  <= frame[bit_idx];
                    cnt <= cnt == LAST ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        bit_idx  <= bit_idx == 4'd9 ? 4'd0 : bit_idx + 4'd1;
                        char_idx <= bit_idx == 4'd9 ? char_idx + 4'd1 : char_idx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_euler_result_uart.sv
// tb_euler_result_uart: decodes the UART line and compares each report against a decimal-string model.
module tb_euler_result_uart;
    localparam int CPB = 4;
    logic clk = 0, rst_n = 1, done = 0, error = 0;
    logic [31:0] result = 0;
    logic tx, busy, sent;
    int checks = 0, errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    int first_start = -1, cap_cyc = -1, busy_len = 0, frame_errs = 0, rx_ph = 0;
    bit rx_act = 0;
    logic [7:0] rx_sh = 0;

    euler_result_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .done(done), .error(error),
        .tx(tx), .busy(busy), .sent(sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_q.delete();
            first_start = -1;
            cap_cyc = -1;
            busy_len = 0;
            frame_errs = 0;
            rx_act = 0;
        end else begin
            if (busy === 1'b1) begin
                busy_len++;
                if (cap_cyc < 0) cap_cyc = cyc;
            end
            if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1;
                    rx_ph = 0;
                    if (first_start < 0) first_start = cyc;
                end
            end else begin
                rx_ph++;
                if (rx_ph % CPB == 0) begin
                    if (rx_ph < 9 * CPB) rx_sh = {tx, rx_sh[7:1]};
                    else begin
                        if (tx !== 1'b1) frame_errs++;
                        rx_q.push_back(rx_sh);
                        rx_act = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int model(input logic [31:0] r, input logic e, output logic [127:0] p);
        logic [7:0] s[$];
        longint v = longint'(r);
        if (e) s = '{8'h45, 8'h52, 8'h52};
        else begin
            do begin
                s.push_front(8'h30 + 8'(v % 10));
                v = v / 10;
            end while (v > 0);
        end
        s.push_back(8'h0D);
        s.push_back(8'h0A);
        p = '0;
        foreach (s[i]) p = {p[119:0], s[i]};
        return s.size();
    endfunction

    function automatic logic [127:0] pack_rx();
        logic [127:0] p = '0;
        foreach (rx_q[i]) p = {p[119:0], rx_q[i]};
        return p;
    endfunction

    task automatic do_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_sent(input string tag);
        for (int i = 0; i < 20000 && sent !== 1'b1; i++) @(negedge clk);
        check({tag, " sent"}, 128'(sent), 128'(1));
        @(negedge clk);
    endtask

    task automatic check_report(input string tag, input logic [31:0] r, input logic e);
        logic [127:0] ep;
        int en, lat;
        en = model(r, e, ep);
        lat = e ? 1 : 33;
        check({tag, " str"}, pack_rx(), ep);
        check({tag, " nchar"}, 128'(rx_q.size()), 128'(en));
        check({tag, " lat"}, 128'(first_start - cap_cyc), 128'(lat));
        check({tag, " busy_len"}, 128'(busy_len), 128'(lat + en * 10 * CPB));
        check({tag, " framing"}, 128'(frame_errs), 128'(0));
        check({tag, " busy_end"}, 128'(busy), 128'(0));
    endtask

    task automatic run(input logic [31:0] r, input logic e, input int hold, input string tag);
        result = r;
        error = e;
        @(posedge clk);
        #1 done = 1;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 done = 0;
        end
        wait_sent(tag);
        check_report(tag, r, e);
    endtask

    initial begin
        int bad, n;
        logic [31:0] r;
        logic e;
        #2 rst_n = 0;
        #1;
        check("rst tx", 128'(tx), 128'(1));
        check("rst busy", 128'(busy), 128'(0));
        check("rst sent", 128'(sent), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle quiet", 128'(bad), 128'(0));
        run(32'd42, 1'b0, 1, "p42");

        do_reset();
        run(32'd31875000, 1'b0, 0, "main");
        repeat (2000) @(negedge clk);
        check("main no_repeat", 128'(rx_q.size()), 128'(10));
        check("main sticky", 128'(sent), 128'(1));
        done = 0;

        do_reset();
        run(32'd0, 1'b0, 0, "zero");
        done = 0;
        do_reset();
        run(32'hFFFF_FFFF, 1'b0, 0, "max");
        done = 0;
        do_reset();
        run(32'd123, 1'b1, 0, "err");
        done = 0;

        do_reset();
        result = 32'd31875000;
        error = 0;
        @(posedge clk);
        #1 done = 1;
        for (int i = 0; i < 100 && busy !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        result = 7;
        error = 1;
        done = 0;
        @(negedge clk);
        done = 1;
        for (int i = 0; i < 2000 && rx_q.size() < 1; i++) @(negedge clk);
        done = 0;
        result = 99;
        repeat (3) @(negedge clk);
        done = 1;
        wait_sent("chg");
        check_report("chg", 32'd31875000, 1'b0);
        repeat (1000) @(negedge clk);
        check("chg no_second", 128'(rx_q.size()), 128'(10));
        done = 0;

        do_reset();
        result = 32'd31875000;
        error = 0;
        done = 1;
        for (int i = 0; i < 2000 && !(rx_q.size() == 2 && rx_act); i++) @(negedge clk);
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst tx", 128'(tx), 128'(1));
        check("midrst busy", 128'(busy), 128'(0));
        check("midrst sent", 128'(sent), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        wait_sent("midrst");
        check_report("midrst", 32'd31875000, 1'b0);
        repeat (1000) @(negedge clk);
        check("midrst once", 128'(rx_q.size()), 128'(10));
        done = 0;

        for (int k = 0; k < 8; k++) begin
            do_reset();
            r = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 999)) : $urandom;
            e = ($urandom_range(0, 5) == 0);
            n = $urandom_range(0, 3);
            run(r, e, n, $sformatf("rnd%0d", k));
            done = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/euler_result_uart.md
# euler_result_uart

Report stage for the Project Euler solver cores: watches a solver's `result`/`done`/`error` outputs and, once per completion, transmits the answer as ASCII decimal over an 8N1 UART line. It sits between any `pNNNN` solver instance and the board's serial TX pin, so answers are read from a terminal instead of from simulation waveforms.

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `result`  in  32  unsigned solver answer; sampled only at capture.
- `done`  in  1  solver completion; level, may stay high indefinitely.
- `error`  in  1  solver failure flag; sampled with `result` at capture.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from capture until the last stop bit ends.
- `sent`  out  1  sticky; high once a report has been fully transmitted.

## Operation
- Reset values: `tx`=1, `busy`=0, `sent`=0, internal `done_q`=0, state IDLE.
- Capture: on an edge in IDLE where `done`=1 and `done_q`=0, latch `result` and `error`, set `busy`=1. `done_q` <= `done` every cycle. Rising edges of `done` outside IDLE are ignored; they are never queued.
- States:
  - IDLE. Wait for capture. Go to SEND if the latched `error`=1, otherwise CONVERT.
  - CONVERT. Double-dabble into 10 BCD digits. Exactly 32 iterations, one per cycle: add 3 to each digit ≥ 5, then shift left by one bit. Then go to SEND.
  - SEND. Transmit the character string one frame at a time, then go to REPORTED.
  - REPORTED. `busy`=0, `sent`=1. Stays here until reset.
- Strings:
  - Error: "ERR\r\n", bytes 0x45 0x52 0x52 0x0D 0x0A.
  - Normal: decimal digits, most significant first, with leading zeros suppressed, then 0x0D 0x0A.
  - Each digit is sent as 0x30 + digit.
  - Value 0 sends the single digit "0".
  - Maximum 12 characters.
- Frame: start bit 0, data bits LSB first, stop bit 1. Each bit is held exactly `CLKS_PER_BIT` cycles. Frames are sent back to back with no idle gap.
- Because REPORTED is terminal, a `done` held high forever produces exactly one report.
- Reset mid-operation:
  - `tx` goes to 1 immediately (asynchronously) and any partial frame is abandoned.
  - All state is cleared.
  - If `done` is still high after `rst_n` deasserts, `done_q`=0 guarantees a fresh capture and a complete new report.

## Timing
- Capture edge C: `busy` rises at C.
- Normal path:
  - CONVERT occupies edges C+1 … C+32.
  - The first start bit drives `tx`=0 from edge C+33.
- Error path: the start bit drives `tx`=0 from edge C+1.
- A report of N characters holds `tx` low/data for N·10·`CLKS_PER_BIT` cycles from the first start-bit edge.
- On the edge that ends the last stop bit: `busy` falls, `sent` rises, `tx` stays 1.
- `result` and `error` may change at any time after C without affecting the report.
- `tx` is a registered output, glitch-free.

## Test plan
- `CLKS_PER_BIT`=4; `result`=31875000, `done` rises and is held → bench UART receiver decodes "31875000\r\n" (10 bytes).
  - First start bit is 33 cycles after capture.
  - `busy` is high for 33+400 cycles.
  - `sent`=1 afterward, and no further frames appear over 2000 more cycles.
- `result`=0 → "0\r\n". `result`=0xFFFFFFFF → "4294967295\r\n".
- `error`=1, `result`=123 → "ERR\r\n", first start bit at C+1. Digits are never sent.
- Change `result` to 7 and toggle `done` low/high while `busy`=1 → the original string is unaffected, and there is no second report.
- Assert `rst_n`=0 in the middle of the 3rd frame of a report of 31875000, with `done` held high throughout.
  - `tx`=1 immediately; `busy`=0 and `sent`=0 during reset.
  - After release, the complete "31875000\r\n" is received exactly once.
- `rst_n` released with `done`=0 for 100 cycles → `tx` stays 1 and `busy` stays 0. Then a `done` pulse of one cycle with `result`=42 → "42\r\n".
